// File: rtl/big_adder_pkg.sv
// Shared constants and elaboration helpers for the pipelined wide adder/subtractor.
// The operand is split into equal chunks, one chunk added per pipeline stage.
package big_adder_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 4;

    function automatic bit split_ok(input int width, input int stages);
        return (stages > 0) && (width > 0) && ((width % stages) == 0);
    endfunction

    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/big_adder_pipe_if.sv
// Operand/result handshake bundle between an operand source (master) and the adder pipe (slave).
interface big_adder_pipe_if #(
    parameter int WIDTH = big_adder_pkg::DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] So;
    logic             c_out;
    logic             ovf;

    modport master (
        output in_valid, a_in, b_in, c_in, sub, out_ready,
        input  in_ready, out_valid, So, c_out, ovf
    );

    modport slave (
        input  in_valid, a_in, b_in, c_in, sub, out_ready,
        output in_ready, out_valid, So, c_out, ovf
    );

endinterface

// File: rtl/adder_chunk.sv
// Combinational W-bit adder slice with carry in and carry out; one instance per pipeline stage.
module adder_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

endmodule

// File: rtl/big_adder_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK per stage, carry registered between stages,
// elastic valid/ready flow control where bubbles collapse and a full pipe sustains one op per cycle.
module big_adder_pipe
    import big_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input logic             clk,
    input logic             rst,
    big_adder_pipe_if.slave bus
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
        $error("big_adder_pipe: WIDTH must be a non-zero multiple of STAGES");
    end

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] adv;

    // A stage may load when it is empty or when the stage after it is also moving.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = ~v[STAGES-1] | bus.out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k] = ~v[k] | adv[k+1];
        end
    end

    assign bus.in_ready = adv[0] & ~rst;

    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int OPW = (STAGES - k) * CHUNK;

        logic [OPW-1:0]   src_a;
        logic [OPW-1:0]   src_b;
        logic [WIDTH-1:0] src_sum;
        logic [WIDTH-1:0] new_sum;
        logic             src_c;
        logic             src_v;
        logic [CHUNK-1:0] s;
        logic             co;
        logic [WIDTH-1:0] sum_q;
        logic             c_q;
        logic             v_q;

        // Stage 0 folds the subtract mode in: B is inverted and the borrow becomes a carry.
        if (k == 0) begin : g_in
            assign src_a   = bus.a_in;
            assign src_b   = bus.sub ? ~bus.b_in : bus.b_in;
            assign src_c   = bus.c_in ^ bus.sub;
            assign src_v   = bus.in_valid & bus.in_ready;
            assign src_sum = '0;
        end else begin : g_in
            assign src_a   = stg[k-1].g_ops.a_q;
            assign src_b   = stg[k-1].g_ops.b_q;
            assign src_c   = stg[k-1].c_q;
            assign src_v   = stg[k-1].v_q;
            assign src_sum = stg[k-1].sum_q;
        end

        adder_chunk #(.W(CHUNK)) u_add (
            .a  (src_a[CHUNK-1:0]),
            .b  (src_b[CHUNK-1:0]),
            .ci (src_c),
            .s  (s),
            .co (co)
        );

        always_comb begin
            new_sum = src_sum;
            new_sum[k*CHUNK +: CHUNK] = s;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q   <= 1'b0;
                sum_q <= '0;
                c_q   <= 1'b0;
            end else if (adv[k]) begin
                v_q   <= src_v;
                sum_q <= new_sum;
                c_q   <= co;
            end
        end

        assign v[k] = v_q;

        // Only the not-yet-added operand chunks travel on; the last stage keeps the overflow flag instead.
        if (k < STAGES - 1) begin : g_ops
            logic [OPW-CHUNK-1:0] a_q;
            logic [OPW-CHUNK-1:0] b_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv[k]) begin
                    a_q <= src_a[OPW-1:CHUNK];
                    b_q <= src_b[OPW-1:CHUNK];
                end
            end
        end else begin : g_last
            logic ovf_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv[k]) begin
                    ovf_q <= (src_a[CHUNK-1] == src_b[CHUNK-1]) & (s[CHUNK-1] != src_a[CHUNK-1]);
                end
            end
        end
    end

    assign bus.out_valid = stg[STAGES-1].v_q;
    assign bus.So        = stg[STAGES-1].sum_q;
    assign bus.c_out     = stg[STAGES-1].c_q;
    assign bus.ovf       = stg[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_big_adder_pipe.sv
// Directed self-checking bench for big_adder_pipe (WIDTH=16, STAGES=4).
module tb_big_adder_pipe;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    big_adder_pipe_if #(.WIDTH(16)) bus ();

    big_adder_pipe #(.WIDTH(16), .STAGES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish, got timeout want completion");
        $fatal(1, "[TB] watchdog");
    end

    // Presents one op, returns the result and the number of edges from acceptance to out_valid.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic s,
                          output logic [15:0] so, output logic co, output logic ov, output int lat);
        bus.a_in      = a;
        bus.b_in      = b;
        bus.c_in      = ci;
        bus.sub       = s;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.out_valid) lat = -1;
        so = bus.So;
        co = bus.c_out;
        ov = bus.ovf;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.c_in      = 1'b0;
        bus.sub       = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 0", bus.in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++;
        if (bus.So !== 16'h0000) begin errors++; $display("[TB] FAIL reset_So got %h want 0000", bus.So); end
        checks++;
        if ({bus.c_out, bus.ovf} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags got %b want 00", {bus.c_out, bus.ovf}); end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_add();
        logic [15:0] va[6] = '{16'hF0F0, 16'h9249, 16'h7FFF, 16'hFFFF, 16'h0001, 16'h8000};
        logic [15:0] vb[6] = '{16'h0F0F, 16'h739C, 16'h0001, 16'h0001, 16'h0001, 16'h8000};
        logic        vc[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] es[6] = '{16'hFFFF, 16'h05E5, 16'h8000, 16'h0000, 16'h0003, 16'h0000};
        logic        ec[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic        eo[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [15:0] so;
        logic        co, ov;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], vc[i], 1'b0, so, co, ov, lat);
            checks++;
            if (so !== es[i]) begin errors++; $display("[TB] FAIL add[%0d] So got %h want %h", i, so, es[i]); end
            checks++;
            if (co !== ec[i]) begin errors++; $display("[TB] FAIL add[%0d] c_out got %b want %b", i, co, ec[i]); end
            checks++;
            if (ov !== eo[i]) begin errors++; $display("[TB] FAIL add[%0d] ovf got %b want %b", i, ov, eo[i]); end
            checks++;
            if (lat != 4) begin errors++; $display("[TB] FAIL add[%0d] latency got %0d want 4", i, lat); end
        end
    endtask

    task automatic test_sub();
        logic [15:0] va[5] = '{16'h0000, 16'h8000, 16'h0005, 16'h1234, 16'h7FFF};
        logic [15:0] vb[5] = '{16'h0001, 16'h0001, 16'h0003, 16'h1234, 16'hFFFF};
        logic        vc[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [15:0] es[5] = '{16'hFFFF, 16'h7FFF, 16'h0001, 16'h0000, 16'h8000};
        logic        ec[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        eo[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [15:0] so;
        logic        co, ov;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], vc[i], 1'b1, so, co, ov, lat);
            checks++;
            if (so !== es[i]) begin errors++; $display("[TB] FAIL sub[%0d] So got %h want %h", i, so, es[i]); end
            checks++;
            if (co !== ec[i]) begin errors++; $display("[TB] FAIL sub[%0d] c_out got %b want %b", i, co, ec[i]); end
            checks++;
            if (ov !== eo[i]) begin errors++; $display("[TB] FAIL sub[%0d] ovf got %b want %b", i, ov, eo[i]); end
            checks++;
            if (lat != 4) begin errors++; $display("[TB] FAIL sub[%0d] latency got %0d want 4", i, lat); end
        end
    endtask

    // Eight ops A=B=i with out_ready dropped for cycles 3..7.
    task automatic test_back_to_back();
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int last_out = -1;
        int acc_at_block = -1;
        bus.sub  = 1'b0;
        bus.c_in = 1'b0;
        while (got < 8 && cyc < 60) begin
            bus.out_ready = !(cyc >= 3 && cyc <= 7);
            bus.in_valid  = (sent < 8);
            bus.a_in      = 16'(sent + 1);
            bus.b_in      = 16'(sent + 1);
            @(negedge clk);
            if (!bus.in_ready && acc_at_block < 0) acc_at_block = sent;
            if (bus.out_valid && !bus.out_ready) begin
                checks++;
                if (bus.So !== 16'h0002) begin errors++; $display("[TB] FAIL b2b_stall_hold cyc %0d So got %h want 0002", cyc, bus.So); end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (bus.So !== 16'((got + 1) * 2)) begin
                    errors++; $display("[TB] FAIL b2b_order[%0d] So got %h want %h", got, bus.So, 16'((got + 1) * 2));
                end
                if (last_out >= 8) begin
                    checks++;
                    if (cyc != last_out + 1) begin errors++; $display("[TB] FAIL b2b_rate cyc got %0d want %0d", cyc, last_out + 1); end
                end
                last_out = cyc;
                got++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        if (acc_at_block != 4) begin errors++; $display("[TB] FAIL b2b_block ops held got %0d want 4", acc_at_block); end
        checks++;
        if (got != 8 || sent != 8) begin errors++; $display("[TB] FAIL b2b_count got %0d/%0d want 8/8", got, sent); end
        checks++;
        if (last_out != 15) begin errors++; $display("[TB] FAIL b2b_last_cycle got %0d want 15", last_out); end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drained out_valid got %b want 0", bus.out_valid); end
    endtask

    // Twelve ops with in_valid and out_ready held high.
    task automatic test_throughput();
        int  sent = 0;
        int  got = 0;
        int  cyc = 0;
        int  first = -1;
        int  last = -1;
        bit  ready_drop = 1'b0;
        bus.out_ready = 1'b1;
        bus.sub       = 1'b0;
        bus.c_in      = 1'b0;
        bus.b_in      = 16'h1000;
        while (got < 12 && cyc < 60) begin
            bus.in_valid = (sent < 12);
            bus.a_in     = 16'(sent);
            @(negedge clk);
            if (bus.in_valid && !bus.in_ready) ready_drop = 1'b1;
            if (bus.out_valid) begin
                checks++;
                if (bus.So !== 16'h1000 + 16'(got)) begin
                    errors++; $display("[TB] FAIL tput_order[%0d] So got %h want %h", got, bus.So, 16'h1000 + 16'(got));
                end
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (ready_drop) begin errors++; $display("[TB] FAIL tput_in_ready got dropped want held 1"); end
        checks++;
        if (first != 4) begin errors++; $display("[TB] FAIL tput_first_cycle got %0d want 4", first); end
        checks++;
        if (got != 12 || (last - first) != 11) begin
            errors++; $display("[TB] FAIL tput_rate got %0d results over %0d cycles want 12 over 11", got, last - first);
        end
    endtask

    // Three ops in flight, one reset cycle with a fourth op offered, then nothing old may emerge.
    task automatic test_reset_mid();
        int          seen = 0;
        logic [15:0] so;
        logic        co, ov;
        int          lat;
        bus.out_ready = 1'b1;
        bus.sub       = 1'b0;
        bus.c_in      = 1'b0;
        bus.a_in      = 16'hFFFF;
        bus.b_in      = 16'hFFFF;
        bus.in_valid  = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        bus.a_in = 16'h4000;
        bus.b_in = 16'h4000;
        rst      = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_in_ready got %b want 0", bus.in_ready); end
        @(posedge clk); #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_out_valid got %b want 0", bus.out_valid); end
        checks++;
        if (bus.So !== 16'h0000) begin errors++; $display("[TB] FAIL rstmid_So got %h want 0000", bus.So); end
        checks++;
        if ({bus.c_out, bus.ovf} !== 2'b00) begin errors++; $display("[TB] FAIL rstmid_flags got %b want 00", {bus.c_out, bus.ovf}); end
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("[TB] FAIL rstmid_ghosts got %0d results want 0", seen); end
        run_op(16'h1234, 16'h0001, 1'b0, 1'b0, so, co, ov, lat);
        checks++;
        if (so !== 16'h1235) begin errors++; $display("[TB] FAIL rstmid_new So got %h want 1235", so); end
        checks++;
        if (lat != 4) begin errors++; $display("[TB] FAIL rstmid_new latency got %0d want 4", lat); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_throughput();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
